// File: rtl/timing_gen_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timing_gen_pkg : run-state, phase and beat encodings shared by timing_gen.
// Revision: 1.0
// ---------------------------------------------------------------------------
package timing_gen_pkg;

    typedef enum logic [0:0] {
        ST_HALT = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    typedef enum logic [1:0] {
        PH_T1 = 2'd0,
        PH_T2 = 2'd1,
        PH_T3 = 2'd2
    } phase_e;

    typedef enum logic [1:0] {
        BT_W1 = 2'd0,
        BT_W2 = 2'd1,
        BT_W3 = 2'd2
    } beat_e;

    localparam int unsigned BEAT_LEN = 3;

    function automatic beat_e next_beat(beat_e cur, logic short_req, logic long_req);
        beat_e nb;
        case (cur)
            BT_W1:   nb = short_req ? BT_W1 : BT_W2;
            BT_W2:   nb = long_req  ? BT_W3 : BT_W1;
            default: nb = BT_W1;
        endcase
        return nb;
    endfunction

    function automatic logic [2:0] onehot3(logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timing_gen_qd_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qd_sync : 2-flop synchronizer plus registered rising-edge detector for qd.
// Revision: 1.0
// ---------------------------------------------------------------------------
module qd_sync (
    input  logic clk,
    input  logic clr,
    input  logic qd,
    output logic qd_pulse
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] fill_q;
    logic       pulse_q;

    // prev_q reads as "already high" until the synchronizer holds a real
    // sample, so a button held through reset release never looks like an edge.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= qd;
            sync_q  <= meta_q;
            fill_q  <= {fill_q[0], 1'b1};
            prev_q  <= fill_q[1] ? sync_q : 1'b1;
            pulse_q <= fill_q[1] & sync_q & ~prev_q;
        end
    end

    assign qd_pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/timing_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timing_gen : beat/phase timing generator with short, long and stop control.
// Revision: 1.0
// ---------------------------------------------------------------------------
module timing_gen
    import timing_gen_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic qd,
    input  logic short_i,
    input  logic long_i,
    input  logic stop_i,
    output logic t1,
    output logic t2,
    output logic t3,
    output logic w1,
    output logic w2,
    output logic w3,
    output logic running
);

    localparam logic [1:0] LAST_PHASE = 2'(BEAT_LEN - 1);

    logic       qd_pulse;
    run_state_e state_q, state_d;
    phase_e     phase_q, phase_d;
    beat_e      beat_q,  beat_d;
    logic [2:0] t_q;
    logic [2:0] w_q;
    logic       running_q;

    qd_sync u_qd_sync (
        .clk      (clk),
        .clr      (clr),
        .qd       (qd),
        .qd_pulse (qd_pulse)
    );

    // beat_q doubles as the pending beat while halted.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        beat_d  = beat_q;
        case (state_q)
            ST_HALT: begin
                if (qd_pulse) begin
                    state_d = ST_RUN;
                    phase_d = PH_T1;
                end
            end
            ST_RUN: begin
                if (phase_q == LAST_PHASE) begin
                    beat_d  = next_beat(beat_q, short_i, long_i);
                    phase_d = PH_T1;
                    if (stop_i) begin
                        state_d = ST_HALT;
                    end
                end else begin
                    phase_d = phase_e'(phase_q + 2'd1);
                end
            end
            default: begin
                state_d = ST_HALT;
                phase_d = PH_T1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_HALT;
            phase_q   <= PH_T1;
            beat_q    <= BT_W1;
            t_q       <= 3'b000;
            w_q       <= 3'b000;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            beat_q    <= beat_d;
            t_q       <= (state_d == ST_RUN) ? onehot3(phase_d) : 3'b000;
            w_q       <= (state_d == ST_RUN) ? onehot3(beat_d)  : 3'b000;
            running_q <= (state_d == ST_RUN);
        end
    end

    assign t1      = t_q[0];
    assign t2      = t_q[1];
    assign t3      = t_q[2];
    assign w1      = w_q[0];
    assign w2      = w_q[1];
    assign w3      = w_q[2];
    assign running = running_q;

endmodule
`default_nettype wire

// File: doc/timing_gen.md
TIMING_GEN -- requirements
Module: timing_gen

Interface
REQ-001 clk  in  1  system clock; all state updates on the rising edge.
REQ-002 clr  in  1  reset, asynchronous and active-low; one clock domain only.
REQ-003 qd  in  1  raw start push-button, asynchronous to clk, active-high.
REQ-004 short_i  in  1  controller request: end the machine cycle after W1.
REQ-005 long_i  in  1  controller request: extend the machine cycle with W3.
REQ-006 stop_i  in  1  controller request: halt after the current beat.
REQ-007 t1, t2, t3  out  1 each  one-hot clock phases inside a beat; each high for exactly one clk.
REQ-008 w1, w2, w3  out  1 each  one-hot beat signals; each held for all three phases of its beat.
REQ-009 running  out  1  high while beats are being issued; low while halted.

Function
REQ-010 State SHALL be {HALT, RUN}, plus a 2-bit phase counter (T1, T2, T3) and a 2-bit beat register (W1, W2, W3).
REQ-011 In RUN, phase SHALL advance T1->T2->T3->T1 on every clk; each beat lasts exactly 3 clk.
REQ-012 Beat transition SHALL be decided only at T3, using short_i/long_i/stop_i sampled on that edge.
REQ-013 Next beat rules: W1 with short_i=1 -> W1; W1 with short_i=0 -> W2; W2 with long_i=1 -> W3; W2 with long_i=0 -> W1; W3 -> W1 regardless of inputs.
REQ-014 If short_i and long_i are both 1 at W1.T3, short_i SHALL win (next beat W1).
REQ-015 If stop_i=1 at T3, the current beat SHALL complete and the state SHALL enter HALT; the computed next beat SHALL be kept as the pending beat.
REQ-016 In HALT, t1..t3 and w1..w3 SHALL all be 0 and running SHALL be 0.
REQ-017 qd SHALL pass through a 2-flop synchronizer followed by rising-edge detection, giving a one-clk qd_pulse.
REQ-018 A qd_pulse in HALT SHALL enter RUN with the pending beat at phase T1 on the next clk edge.
REQ-019 The first t1 SHALL rise on the 3rd clk rising edge after the first edge that samples qd=1.
REQ-020 qd_pulse in RUN SHALL be ignored; holding qd high SHALL produce only one pulse.
REQ-021 If stop_i=1 at T3 and qd_pulse fires on the same edge, HALT SHALL be entered and the pulse discarded.
REQ-022 Outputs SHALL be registered (no combinational path from inputs to t*/w*).

Reset
REQ-023 While clr=0: state=HALT, pending beat=W1, phase=T1, synchronizer flops=0; all outputs 0.
REQ-024 clr asserted mid-beat SHALL clear all outputs immediately (asynchronously) and abandon the beat.
REQ-025 After clr deasserts, no beat SHALL issue until a fresh qd rising edge; qd held high through the release SHALL not start the machine.

Structure
REQ-026 The shared package SHALL hold the run-state enum, the phase and beat encodings, and the beat-length constant 3.
REQ-027 The synchronizer and edge detector SHALL be a sub-module named qd_sync (ports clk, clr, qd, qd_pulse).
REQ-028 The implementation SHALL be 120-400 lines of RTL in total.

Verification
REQ-029 Reset, then qd pulse with short_i=long_i=stop_i=0 -> beat sequence W1,W2,W1,W2, 3 clk each; t1/t2/t3 rotate; running=1.
REQ-030 short_i=1 held -> w1 stays high continuously; w2 and w3 are never asserted over 12 clk.
REQ-031 long_i=1 at W2.T3 -> W3 is issued for 3 clk, then W1; with short_i=long_i=1 at W1.T3 -> next beat is W1.
REQ-032 stop_i=1 at W1.T3 (short_i=0) -> all outputs 0 from the next clk; a qd pulse 10 clk later -> W2.T1 rises exactly 3 clk after qd is sampled.
REQ-033 clr=0 pulsed during W2.T2 -> outputs drop without waiting for clk; qd held high across the clr release -> no beats until qd goes 0 then 1 again.
REQ-034 qd toggled during RUN and qd coinciding with stop at T3 -> beat sequence unaffected; the machine stays in HALT afterwards.
